// File: rtl/trade_sma_pkg.sv
// Shared types and width helpers for the SMA trend/position engine.
// The trade processing unit imports the same helpers so that its score and count
// widths always match the widths this engine produces.
package trade_sma_pkg;

    typedef enum logic [1:0] {
        POS_FLAT     = 2'd0,
        POS_LONG     = 2'd1,
        POS_SHORT    = 2'd2,
        POS_COOLDOWN = 2'd3
    } pos_state_t;

    // Full-precision signed score width.
    // One bit is for the sign of each difference. clog2(np) bits are for the sum.
    // The last bit is headroom, so the score can be negated without wrapping.
    function automatic int score_width(input int dw, input int np);
        return dw + 1 + $clog2(np) + 1;
    endfunction

    // Width needed to count 0..n set bits.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sma_popcount.sv
// Purely combinational count of the set bits in a vector.
module sma_popcount #(
    parameter int N = 6,
    parameter int W = $clog2(N + 1)
) (
    input  logic [N-1:0] bits,
    output logic [W-1:0] count
);

    // Add each bit into a running total.
    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + W'(bits[i]);
        end
    end

endmodule

// File: rtl/trade_sma_engine.sv
// Trend engine that sits between the SMA pre-processing block and the trade processing unit.
//
// Pipeline stages:
//   Stage 1 registers the per-SMA rising/falling flags against the previous accepted sample.
//   Stage 1 also registers the fast-minus-slow differences.
//   Stage 2 sums the score and counts the confluence.
//   Stage 2 then runs the position FSM and registers the outputs.
//
// Handshake: there is no backpressure.
//   Every cycle with data_valid_pre high is accepted.
//   Exactly two cycles later, data_valid_sma is high for one cycle.
//   buy_signal and sell_signal are only ever high in a data_valid_sma cycle.
//   position is the FSM state itself and can be read in any cycle.
module trade_sma_engine
    import trade_sma_pkg::*;
#(
    parameter int DATA_WIDTH           = 8,
    parameter int NUM_SMA              = 6,
    parameter int NUM_PAIRS            = 2,
    parameter int ENTRY_THRESHOLD      = 77,
    parameter int EXIT_THRESHOLD       = 20,
    parameter int CONFLUENCE_THRESHOLD = 3,
    parameter int COOLDOWN_SAMPLES     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          data_valid_pre,
    input  logic [NUM_SMA*DATA_WIDTH-1:0] sma_in,
    output logic                          buy_signal,
    output logic                          sell_signal,
    output logic [1:0]                    position,
    output logic                          data_valid_sma
);

    localparam int DW1     = DATA_WIDTH + 1;
    localparam int SW      = score_width(DATA_WIDTH, NUM_PAIRS);
    localparam int CW      = cnt_width(NUM_SMA);
    localparam int CDW     = (COOLDOWN_SAMPLES > 1) ? $clog2(COOLDOWN_SAMPLES) : 1;
    localparam int CD_LOAD = (COOLDOWN_SAMPLES > 0) ? COOLDOWN_SAMPLES - 1 : 0;

    localparam logic signed [SW-1:0] ENTRY_S = SW'(ENTRY_THRESHOLD);
    localparam logic signed [SW-1:0] EXIT_S  = SW'(EXIT_THRESHOLD);
    localparam logic [CW-1:0]        CONF_C  = CW'(CONFLUENCE_THRESHOLD);

    // An exit goes to COOLDOWN, unless the cooldown is disabled.
    localparam pos_state_t EXIT_STATE = (COOLDOWN_SAMPLES == 0) ? POS_FLAT : POS_COOLDOWN;

    // ---------------- stage 1 state ----------------
    logic [NUM_SMA*DATA_WIDTH-1:0] prev_d,    prev_q;
    logic                          primed_d,  primed_q;
    logic [NUM_SMA-1:0]            rising_d,  rising_q;
    logic [NUM_SMA-1:0]            falling_d, falling_q;
    logic [NUM_PAIRS*DW1-1:0]      diff_d,    diff_q;
    logic                          warm1_d,   warm1_q;
    logic                          valid1_d,  valid1_q;

    // ---------------- stage 2 / FSM state ----------------
    pos_state_t                    state_d,   state_q;
    logic [CDW-1:0]                cd_cnt_d,  cd_cnt_q;
    logic                          buy_d,     buy_q;
    logic                          sell_d,    sell_q;
    logic                          dv_d,      dv_q;

    logic signed [SW-1:0]          score;
    logic signed [SW-1:0]          neg_score;
    logic [CW-1:0]                 up_cnt;
    logic [CW-1:0]                 dn_cnt;
    logic                          long_cond;
    logic                          short_cond;
    logic                          long_exit;
    logic                          short_exit;

    // Stage 1: compare the sample against the history, capture the pair differences, and update the history.
    // Idle cycles hold every register, so gaps never disturb the trend comparison.
    always_comb begin
        prev_d    = prev_q;
        primed_d  = primed_q;
        rising_d  = rising_q;
        falling_d = falling_q;
        diff_d    = diff_q;
        warm1_d   = warm1_q;
        valid1_d  = data_valid_pre;
        if (data_valid_pre) begin
            prev_d   = sma_in;
            primed_d = 1'b1;
            warm1_d  = !primed_q;
            for (int i = 0; i < NUM_SMA; i++) begin
                rising_d[i]  = sma_in[i*DATA_WIDTH +: DATA_WIDTH] > prev_q[i*DATA_WIDTH +: DATA_WIDTH];
                falling_d[i] = sma_in[i*DATA_WIDTH +: DATA_WIDTH] < prev_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
            for (int k = 0; k < NUM_PAIRS; k++) begin
                diff_d[k*DW1 +: DW1] = {1'b0, sma_in[k*DATA_WIDTH +: DATA_WIDTH]}
                                     - {1'b0, sma_in[(k+NUM_PAIRS)*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_q    <= '0;
            primed_q  <= 1'b0;
            rising_q  <= '0;
            falling_q <= '0;
            diff_q    <= '0;
            warm1_q   <= 1'b0;
            valid1_q  <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            primed_q  <= primed_d;
            rising_q  <= rising_d;
            falling_q <= falling_d;
            diff_q    <= diff_d;
            warm1_q   <= warm1_d;
            valid1_q  <= valid1_d;
        end
    end

    sma_popcount #(.N(NUM_SMA), .W(CW)) u_up_cnt (.bits(rising_q),  .count(up_cnt));
    sma_popcount #(.N(NUM_SMA), .W(CW)) u_dn_cnt (.bits(falling_q), .count(dn_cnt));

    // Stage 2: sum the sign-extended differences at full precision.
    always_comb begin
        score = '0;
        for (int k = 0; k < NUM_PAIRS; k++) begin
            score = score + SW'(signed'(diff_q[k*DW1 +: DW1]));
        end
    end

    assign neg_score = -score;

    // The warm-up sample only primes the history.
    // Every entry and exit condition is masked for that sample.
    assign long_cond  = !warm1_q && (score > ENTRY_S) && (up_cnt >= CONF_C);
    assign short_cond = !warm1_q && (neg_score > ENTRY_S) && (dn_cnt >= CONF_C);
    assign long_exit  = !warm1_q && (score < EXIT_S);
    assign short_exit = !warm1_q && (neg_score < EXIT_S);

    // Position FSM next-state logic. The FSM only advances on cycles where a stage-1 result is valid.
    always_comb begin
        state_d  = state_q;
        cd_cnt_d = cd_cnt_q;
        buy_d    = 1'b0;
        sell_d   = 1'b0;
        dv_d     = valid1_q;
        if (valid1_q) begin
            case (state_q)
                POS_FLAT: begin
                    if (long_cond) begin
                        state_d = POS_LONG;
                        buy_d   = 1'b1;
                    end else if (short_cond) begin
                        state_d = POS_SHORT;
                        sell_d  = 1'b1;
                    end
                end
                POS_LONG: begin
                    // A strong reversal only closes the position.
                    // A short needs a fresh entry from FLAT.
                    if (long_exit) begin
                        state_d  = EXIT_STATE;
                        cd_cnt_d = CDW'(CD_LOAD);
                        sell_d   = 1'b1;
                    end
                end
                POS_SHORT: begin
                    if (short_exit) begin
                        state_d  = EXIT_STATE;
                        cd_cnt_d = CDW'(CD_LOAD);
                        buy_d    = 1'b1;
                    end
                end
                POS_COOLDOWN: begin
                    if (cd_cnt_q == '0) begin
                        state_d = POS_FLAT;
                    end else begin
                        cd_cnt_d = cd_cnt_q - CDW'(1);
                    end
                end
                default: state_d = POS_FLAT;
            endcase
        end
    end

    // Stage 2 registers: FSM state, cooldown counter and the registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= POS_FLAT;
            cd_cnt_q <= '0;
            buy_q    <= 1'b0;
            sell_q   <= 1'b0;
            dv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cd_cnt_q <= cd_cnt_d;
            buy_q    <= buy_d;
            sell_q   <= sell_d;
            dv_q     <= dv_d;
        end
    end

    assign buy_signal     = buy_q;
    assign sell_signal    = sell_q;
    assign data_valid_sma = dv_q;
    assign position       = state_q;

endmodule

// File: tb/tb_trade_sma_engine.sv
// Bench for trade_sma_engine.
// The driver pushes the expected {cycle, buy, sell, position} for every accepted sample onto a queue.
// A monitor pops one entry each time data_valid_sma is seen and compares it.
module tb_trade_sma_engine;

    localparam int DW    = 8;
    localparam int N     = 6;
    localparam int NP    = 2;
    localparam int ENTRY = 77;
    localparam int EXITT = 20;
    localparam int CONF  = 3;
    localparam int CD    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          data_valid_pre;
    logic [N*DW-1:0] sma_in;
    logic          buy_signal;
    logic          sell_signal;
    logic [1:0]    position;
    logic          data_valid_sma;

    trade_sma_engine #(
        .DATA_WIDTH(DW), .NUM_SMA(N), .NUM_PAIRS(NP),
        .ENTRY_THRESHOLD(ENTRY), .EXIT_THRESHOLD(EXITT),
        .CONFLUENCE_THRESHOLD(CONF), .COOLDOWN_SAMPLES(CD)
    ) dut (
        .clk(clk), .rst(rst), .data_valid_pre(data_valid_pre), .sma_in(sma_in),
        .buy_signal(buy_signal), .sell_signal(sell_signal),
        .position(position), .data_valid_sma(data_valid_sma)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int          tests = 0;
    int          fails = 0;
    logic [19:0] exp_q[$];
    logic [19:0] exp_e;
    logic [19:0] got_e;
    logic [1:0]  last_pos = 2'd0;

    // ---------------- reference model ----------------
    // The position is kept as 0 FLAT, 1 LONG, 2 SHORT, 3 COOLDOWN.
    // m_rem is the number of cooldown samples still to be spent.
    int m_prev[N];
    bit m_primed;
    int m_pos;
    int m_rem;

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_prev[i] = 0;
        m_primed = 1'b0;
        m_pos    = 0;
        m_rem    = 0;
    endtask

    task automatic model_step(input logic [N*DW-1:0] v, output logic b, output logic s,
                              output logic [1:0] p);
        int val[N];
        int score;
        int up;
        int dn;
        b = 1'b0;
        s = 1'b0;
        for (int i = 0; i < N; i++) val[i] = int'(v[i*DW +: DW]);
        score = 0;
        for (int k = 0; k < NP; k++) score += val[k] - val[k+NP];
        up = 0;
        dn = 0;
        for (int i = 0; i < N; i++) begin
            if (val[i] > m_prev[i]) up++;
            if (val[i] < m_prev[i]) dn++;
        end
        if (!m_primed) begin
            m_primed = 1'b1;
        end else begin
            case (m_pos)
                0: begin
                    if (score > ENTRY && up >= CONF) begin
                        m_pos = 1; b = 1'b1;
                    end else if (-score > ENTRY && dn >= CONF) begin
                        m_pos = 2; s = 1'b1;
                    end
                end
                1: if (score < EXITT) begin
                    s = 1'b1;
                    if (CD == 0) m_pos = 0; else begin m_pos = 3; m_rem = CD; end
                end
                2: if (-score < EXITT) begin
                    b = 1'b1;
                    if (CD == 0) m_pos = 0; else begin m_pos = 3; m_rem = CD; end
                end
                default: begin
                    m_rem--;
                    if (m_rem == 0) m_pos = 0;
                end
            endcase
        end
        for (int i = 0; i < N; i++) m_prev[i] = val[i];
        p = 2'(m_pos);
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic [N*DW-1:0] p6(input int a0, input int a1, input int a2,
                                           input int a3, input int a4, input int a5);
        return {8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    // Called just after a rising edge. The edge that follows captures the sample.
    // The result is expected in the cycle two edges later.
    task automatic send(input logic [N*DW-1:0] v, input int gap);
        logic b;
        logic s;
        logic [1:0] p;
        logic [15:0] stamp;
        model_step(v, b, s, p);
        stamp = 16'(cyc + 2);
        exp_q.push_back({stamp, b, s, p});
        data_valid_pre = 1'b1;
        sma_in         = v;
        @(posedge clk);
        #1;
        data_valid_pre = 1'b0;
        sma_in         = $urandom();
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        for (int g = 0; g < n; g++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_quiet();
        tests++;
        if (buy_signal || sell_signal || data_valid_sma || position != 2'd0) begin
            fails++;
            $display("FAIL reset_hold: buy=%0b sell=%0b dv=%0b pos=%0d, required all 0",
                     buy_signal, sell_signal, data_valid_sma, position);
        end
    endtask

    // Any sample still in flight is discarded. The model and the expected queue start over.
    task automatic do_reset(input int n);
        rst = 1'b0;
        exp_q.delete();
        model_reset();
        last_pos = 2'd0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            @(negedge clk);
            check_quiet();
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            if (data_valid_sma) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_dv: cycle=%0d buy=%0b sell=%0b pos=%0d, required no output",
                             cyc, buy_signal, sell_signal, position);
                end else begin
                    exp_e = exp_q.pop_front();
                    got_e = {cyc[15:0], buy_signal, sell_signal, position};
                    if (got_e !== exp_e) begin
                        fails++;
                        $display("FAIL result: got cycle=%0d buy=%0b sell=%0b pos=%0d, required cycle=%0d buy=%0b sell=%0b pos=%0d",
                                 got_e[19:4], got_e[3], got_e[2], got_e[1:0],
                                 exp_e[19:4], exp_e[3], exp_e[2], exp_e[1:0]);
                    end
                    last_pos = exp_e[1:0];
                end
            end else begin
                tests++;
                if (buy_signal || sell_signal || position !== last_pos) begin
                    fails++;
                    $display("FAIL idle_outputs: cycle=%0d buy=%0b sell=%0b pos=%0d, required buy=0 sell=0 pos=%0d",
                             cyc, buy_signal, sell_signal, position, last_pos);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int mode;
    int burst;
    int vals[N];
    int gap;
    int guard;
    logic [N*DW-1:0] rv;

    initial begin
        rst            = 1'b0;
        data_valid_pre = 1'b0;
        sma_in         = '0;
        model_reset();
        do_reset(3);

        // Warm-up sample: it only primes the history.
        send(p6(100, 100, 100, 100, 100, 100), 3);

        // Long entry. A strong score with too little confluence does not enter. Then a real entry.
        send(p6(50, 50, 60, 60, 60, 60), 0);
        send(p6(200, 180, 60, 50, 50, 50), 0);
        send(p6(210, 190, 61, 51, 51, 51), 0);
        // Hysteresis: a score of 30 holds the position. A score of 10 exits into cooldown.
        send(p6(100, 100, 85, 85, 85, 85), 0);
        send(p6(100, 100, 95, 95, 95, 95), 0);
        // Cooldown ignores four strong long samples. The fifth one enters.
        for (int i = 0; i < 5; i++) send(p6(200+i, 200+i, 100+i, 100+i, 100+i, 100+i), 0);
        send(p6(105, 105, 105, 105, 105, 105), 0);
        for (int i = 0; i < 4; i++) send(p6(105, 105, 105, 105, 105, 105), 0);
        // Short entry at a score of -510. Holding it checks that the negation does not wrap. Then exit.
        send(p6(0, 0, 255, 255, 0, 0), 0);
        send(p6(0, 0, 255, 255, 0, 0), 0);
        send(p6(100, 100, 100, 100, 100, 100), 0);

        // The same long entry/exit sequence, with 5 idle cycles between samples.
        for (int i = 0; i < 4; i++) send(p6(100, 100, 100, 100, 100, 100), 5);
        send(p6(50, 50, 60, 60, 60, 60), 5);
        send(p6(200, 180, 60, 50, 50, 50), 5);
        send(p6(210, 190, 61, 51, 51, 51), 5);
        send(p6(100, 100, 95, 95, 95, 95), 5);
        for (int i = 0; i < 4; i++) send(p6(100, 100, 100, 100, 100, 100), 5);

        // A reset one cycle after an entry sample discards that sample.
        send(p6(250, 250, 120, 120, 120, 120), 0);
        do_reset(2);
        send(p6(100, 100, 100, 100, 100, 100), 0);
        send(p6(250, 250, 120, 120, 120, 120), 4);

        // Randomized bursts: uniform noise, up/down trends and near-flat drift.
        burst = 0;
        mode  = 0;
        for (int n = 0; n < 400; n++) begin
            if (burst == 0) begin
                mode  = $urandom_range(0, 3);
                burst = $urandom_range(2, 8);
            end
            burst--;
            for (int i = 0; i < N; i++) begin
                case (mode)
                    0: vals[i] = $urandom_range(0, 255);
                    1: begin
                        vals[i] = m_prev[i] + ((i < NP) ? $urandom_range(10, 60) : $urandom_range(0, 15));
                        if (vals[i] > 255) vals[i] = 255;
                    end
                    2: begin
                        vals[i] = m_prev[i] - ((i < NP) ? $urandom_range(10, 60) : $urandom_range(0, 15));
                        if (vals[i] < 0) vals[i] = 0;
                    end
                    default: begin
                        vals[i] = m_prev[i] + $urandom_range(0, 4) - 2;
                        if (vals[i] < 0) vals[i] = 0;
                        if (vals[i] > 255) vals[i] = 255;
                    end
                endcase
                rv[i*DW +: DW] = 8'(vals[i]);
            end
            gap = ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 1);
            send(rv, gap);
            if ($urandom_range(0, 99) == 0) do_reset($urandom_range(1, 3));
        end

        // Drain the remaining results within a bounded number of cycles.
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        idle(3);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
